// File: rtl/cfu_issue_unit.sv
// rtl/cfu_issue_unit.sv - issue/writeback bridge between a core and a custom function unit
// Single request register, 2-entry response FIFO, outstanding tracker with timeout.
module cfu_issue_unit #(
  parameter int ID_W            = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               issue_valid,
  output logic                               issue_ready,
  input  logic [ID_W-1:0]                    issue_id,
  input  logic [31:0]                        issue_rs1,
  input  logic [31:0]                        issue_rs2,
  output logic                               cfu_req_valid,
  input  logic                               cfu_req_ready,
  output logic [ID_W-1:0]                    cfu_req_id,
  output logic [31:0]                        cfu_req_data0,
  output logic [31:0]                        cfu_req_data1,
  input  logic                               cfu_resp_valid,
  output logic                               cfu_resp_ready,
  input  logic [ID_W-1:0]                    cfu_resp_id,
  input  logic [31:0]                        cfu_resp_data,
  input  logic [2:0]                         cfu_resp_status,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [ID_W-1:0]                    wb_id,
  output logic [31:0]                        wb_data,
  output logic [2:0]                         wb_status,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               timeout_err
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int EW = ID_W + 35;

  typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic [OW-1:0] out_next;
  logic          issue_fire, req_fire, resp_fire, wb_fire, wb_dec;

  logic [1:0]    fifo_cnt;
  logic          wr_ptr, rd_ptr;
  logic [EW-1:0] fifo_mem [2];

  assign issue_ready = rst_n & (~cfu_req_valid | cfu_req_ready)
                     & (outstanding < OW'(MAX_OUTSTANDING)) & ~timeout_err;
  assign cfu_resp_ready = rst_n & (fifo_cnt != 2'd2);
  assign wb_valid = (fifo_cnt != 2'd0);
  assign {wb_id, wb_data, wb_status} = fifo_mem[rd_ptr];

  assign issue_fire = issue_valid & issue_ready;
  assign req_fire   = cfu_req_valid & cfu_req_ready;
  assign resp_fire  = cfu_resp_valid & cfu_resp_ready;
  assign wb_fire    = wb_valid & wb_ready;
  // A writeback with nothing outstanding (unchecked IDs) must not wrap the count.
  assign wb_dec     = wb_fire & (outstanding != '0);

  always_comb begin
    out_next = outstanding;
    if (issue_fire && !wb_dec)
      out_next = outstanding + OW'(1);
    else if (!issue_fire && wb_dec)
      out_next = outstanding - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cfu_req_valid <= 1'b0;
    else if (issue_fire)
      cfu_req_valid <= 1'b1;
    else if (req_fire)
      cfu_req_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      cfu_req_id    <= issue_id;
      cfu_req_data0 <= issue_rs1;
      cfu_req_data1 <= issue_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (resp_fire) wr_ptr <= ~wr_ptr;
      if (wb_fire)   rd_ptr <= ~rd_ptr;
      case ({resp_fire, wb_fire})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resp_fire)
      fifo_mem[wr_ptr] <= {cfu_resp_id, cfu_resp_data, cfu_resp_status};
  end

  // Tracker: ERROR is terminal until reset; the datapath keeps draining in ERROR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (issue_fire) state <= BUSY;
        end
        BUSY: begin
          if (out_next == '0) begin
            state   <= IDLE;
            tmo_cnt <= '0;
          end else if (resp_fire) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              state       <= ERROR;
              timeout_err <= 1'b1;
            end
          end
        end
        ERROR: begin
          state       <= ERROR;
          timeout_err <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          timeout_err <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_issue_unit.sv
// tb/tb_cfu_issue_unit.sv - directed scoreboard bench for cfu_issue_unit
module tb_cfu_issue_unit;
  localparam int ID_W = 3;
  localparam int MAXO = 4;
  localparam int TMO  = 10;
  localparam int OW   = $clog2(MAXO + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid, issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [31:0]     issue_rs1, issue_rs2;
  logic            cfu_req_valid, cfu_req_ready;
  logic [ID_W-1:0] cfu_req_id;
  logic [31:0]     cfu_req_data0, cfu_req_data1;
  logic            cfu_resp_valid, cfu_resp_ready;
  logic [ID_W-1:0] cfu_resp_id;
  logic [31:0]     cfu_resp_data;
  logic [2:0]      cfu_resp_status;
  logic            wb_valid, wb_ready;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_data;
  logic [2:0]      wb_status;
  logic [OW-1:0]   outstanding;
  logic            timeout_err;

  always #5 clk = ~clk;

  cfu_issue_unit #(.ID_W(ID_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready), .cfu_req_id(cfu_req_id),
    .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready), .cfu_resp_id(cfu_resp_id),
    .cfu_resp_data(cfu_resp_data), .cfu_resp_status(cfu_resp_status),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_id(wb_id), .wb_data(wb_data),
    .wb_status(wb_status), .outstanding(outstanding), .timeout_err(timeout_err)
  );

  typedef struct packed {logic [ID_W-1:0] id; logic [31:0] rs1; logic [31:0] rs2;} req_t;
  typedef struct packed {logic [ID_W-1:0] id; logic [31:0] data; logic [2:0] st;} wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes that complete at the coming edge are visible at the negedge.
  always @(negedge clk) begin : mon
    req_t r;
    wb_t  w;
    if (rst_n && wb_valid && wb_ready) begin
      check("wb_expected", 64'(wb_q.size() != 0), 64'(1));
      if (wb_q.size() != 0) begin
        w = wb_q.pop_front();
        check("wb_id", 64'(wb_id), 64'(w.id));
        check("wb_data", 64'(wb_data), 64'(w.data));
        check("wb_status", 64'(wb_status), 64'(w.st));
      end
    end
    if (rst_n && cfu_req_valid && cfu_req_ready) begin
      check("req_expected", 64'(req_q.size() != 0), 64'(1));
      if (req_q.size() != 0) begin
        r = req_q.pop_front();
        check("req_id", 64'(cfu_req_id), 64'(r.id));
        check("req_data0", 64'(cfu_req_data0), 64'(r.rs1));
        check("req_data1", 64'(cfu_req_data1), 64'(r.rs2));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; issue_valid = 1'b0; cfu_req_ready = 1'b0;
    cfu_resp_valid = 1'b0; wb_ready = 1'b0;
    req_q.delete(); wb_q.delete();
    tick(); tick();
    check("rst_issue_ready", 64'(issue_ready), 64'(0));
    check("rst_resp_ready", 64'(cfu_resp_ready), 64'(0));
    check("rst_req_valid", 64'(cfu_req_valid), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [31:0] b);
    logic ok = 1'b0;
    issue_valid = 1'b1; issue_id = id; issue_rs1 = a; issue_rs2 = b;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (issue_ready) begin
        req_q.push_back('{id: id, rs1: a, rs2: b});
        ok = 1'b1;
      end
      tick();
    end
    issue_valid = 1'b0;
    check("issue_accepted", 64'(ok), 64'(1));
  endtask

  task automatic resp(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [2:0] st);
    logic ok = 1'b0;
    cfu_resp_valid = 1'b1; cfu_resp_id = id; cfu_resp_data = d; cfu_resp_status = st;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (cfu_resp_ready) begin
        wb_q.push_back('{id: id, data: d, st: st});
        ok = 1'b1;
      end
      tick();
    end
    cfu_resp_valid = 1'b0;
    check("resp_accepted", 64'(ok), 64'(1));
  endtask

  initial begin
    issue_id = '0; issue_rs1 = '0; issue_rs2 = '0;
    cfu_resp_id = '0; cfu_resp_data = '0; cfu_resp_status = '0;

    // Single op
    do_reset();
    cfu_req_ready = 1'b1; wb_ready = 1'b1;
    check("single_out0", 64'(outstanding), 64'(0));
    issue(3'd2, 32'h5, 32'h3);
    check("single_out1", 64'(outstanding), 64'(1));
    check("single_req_valid", 64'(cfu_req_valid), 64'(1));
    tick();
    resp(3'd2, 32'hFFFF_FFF9, 3'd0);
    check("single_wb_valid", 64'(wb_valid), 64'(1));
    check("single_wb_data", 64'(wb_data), 64'(32'hFFFF_FFF9));
    tick();
    check("single_wb_gone", 64'(wb_valid), 64'(0));
    check("single_out_end", 64'(outstanding), 64'(0));

    // Outstanding limit
    do_reset();
    cfu_req_ready = 1'b1; wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(3'(k), 32'h100 + 32'(k), 32'h200 + 32'(k));
      check("limit_out", 64'(outstanding), 64'(k + 1));
    end
    check("limit_ready_low", 64'(issue_ready), 64'(0));
    resp(3'd0, 32'hA0, 3'd1);
    check("limit_ready_still_low", 64'(issue_ready), 64'(0));
    wb_ready = 1'b1;
    tick();
    check("limit_out3", 64'(outstanding), 64'(3));
    check("limit_ready_back", 64'(issue_ready), 64'(1));
    resp(3'd1, 32'hA1, 3'd2);
    resp(3'd2, 32'hA2, 3'd3);
    resp(3'd3, 32'hA3, 3'd4);
    tick(); tick();
    check("limit_drained", 64'(outstanding), 64'(0));
    check("limit_sb_empty", 64'(wb_q.size()), 64'(0));

    // Writeback backpressure
    do_reset();
    cfu_req_ready = 1'b1; wb_ready = 1'b0;
    issue(3'd5, 32'h1, 32'h2);
    issue(3'd6, 32'h3, 32'h4);
    issue(3'd7, 32'h5, 32'h6);
    resp(3'd5, 32'hB5, 3'd0);
    resp(3'd6, 32'hB6, 3'd1);
    cfu_resp_valid = 1'b1; cfu_resp_id = 3'd7; cfu_resp_data = 32'hB7; cfu_resp_status = 3'd2;
    tick(); tick();
    check("bp_resp_ready_low", 64'(cfu_resp_ready), 64'(0));
    check("bp_wb_valid", 64'(wb_valid), 64'(1));
    check("bp_head_stable", 64'(wb_id), 64'(5));
    wb_ready = 1'b1;
    resp(3'd7, 32'hB7, 3'd2);
    tick(); tick(); tick();
    check("bp_sb_empty", 64'(wb_q.size()), 64'(0));
    check("bp_wb_idle", 64'(wb_valid), 64'(0));
    check("bp_out0", 64'(outstanding), 64'(0));

    // Simultaneous issue and writeback
    do_reset();
    cfu_req_ready = 1'b1; wb_ready = 1'b0;
    issue(3'd1, 32'h11, 32'h12);
    issue(3'd2, 32'h21, 32'h22);
    resp(3'd1, 32'hC1, 3'd0);
    check("sim_out2_before", 64'(outstanding), 64'(2));
    wb_ready = 1'b1;
    issue(3'd3, 32'h31, 32'h32);
    check("sim_out2_after", 64'(outstanding), 64'(2));
    resp(3'd2, 32'hC2, 3'd1);
    resp(3'd3, 32'hC3, 3'd2);
    tick(); tick();
    check("sim_out0", 64'(outstanding), 64'(0));

    // Timeout
    do_reset();
    cfu_req_ready = 1'b1; wb_ready = 1'b1;
    issue(3'd4, 32'h44, 32'h45);
    repeat (9) tick();
    check("tmo_not_yet", 64'(timeout_err), 64'(0));
    tick();
    check("tmo_flag", 64'(timeout_err), 64'(1));
    check("tmo_issue_blocked", 64'(issue_ready), 64'(0));
    issue_valid = 1'b1; issue_id = 3'd5;
    tick(); tick();
    issue_valid = 1'b0;
    check("tmo_no_accept", 64'(outstanding), 64'(1));
    resp(3'd4, 32'h1234_5678, 3'd5);
    tick(); tick();
    check("tmo_late_drained", 64'(wb_q.size()), 64'(0));
    check("tmo_out0", 64'(outstanding), 64'(0));
    check("tmo_sticky", 64'(timeout_err), 64'(1));
    do_reset();

    // Mid-operation reset
    cfu_req_ready = 1'b1; wb_ready = 1'b0;
    issue(3'd1, 32'h71, 32'h72);
    issue(3'd2, 32'h81, 32'h82);
    resp(3'd1, 32'hD1, 3'd0);
    resp(3'd2, 32'hD2, 3'd0);
    cfu_req_ready = 1'b0;
    issue(3'd3, 32'h91, 32'h92);
    check("mid_wb_valid", 64'(wb_valid), 64'(1));
    check("mid_req_valid", 64'(cfu_req_valid), 64'(1));
    check("mid_fifo_full", 64'(cfu_resp_ready), 64'(0));
    rst_n = 1'b0;
    req_q.delete(); wb_q.delete();
    tick();
    check("mid_req_cleared", 64'(cfu_req_valid), 64'(0));
    check("mid_wb_cleared", 64'(wb_valid), 64'(0));
    check("mid_out_cleared", 64'(outstanding), 64'(0));
    rst_n = 1'b1;
    tick();
    check("mid_resp_ready", 64'(cfu_resp_ready), 64'(1));
    check("mid_issue_ready", 64'(issue_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/cfu_issue_unit.md
CFU_ISSUE_UNIT -- requirements
Module: cfu_issue_unit

Interface
REQ-001 Parameter ID_W, default 3, width of request/response IDs.
REQ-002 Parameter MAX_OUTSTANDING, default 4, limit on requests accepted but not yet written back (1..2**ID_W).
REQ-003 Parameter TIMEOUT, default 255, cycles without a CFU response (while requests are outstanding) before an error is flagged.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 issue_valid / issue_ready  in / out  1 / 1  core-to-unit issue handshake.
REQ-007 issue_id / issue_rs1 / issue_rs2  in  ID_W / 32 / 32  issue payload.
REQ-008 cfu_req_valid / cfu_req_ready  out / in  1 / 1  request handshake to the CFU.
REQ-009 cfu_req_id / cfu_req_data0 / cfu_req_data1  out  ID_W / 32 / 32  request payload.
REQ-010 cfu_resp_valid / cfu_resp_ready  in / out  1 / 1  response handshake from the CFU.
REQ-011 cfu_resp_id / cfu_resp_data / cfu_resp_status  in  ID_W / 32 / 3  response payload.
REQ-012 wb_valid / wb_ready  out / in  1 / 1  writeback handshake to the core.
REQ-013 wb_id / wb_data / wb_status  out  ID_W / 32 / 3  writeback payload.
REQ-014 outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
REQ-015 timeout_err  out  1  sticky timeout flag.

Function
REQ-016 A transfer occurs on any interface only in a cycle where valid and ready are both 1 at the rising edge.
REQ-017 Request register: single entry; loads issue_id/rs1/rs2 into cfu_req_id/data0/data1 on issue accept and sets cfu_req_valid.
REQ-018 cfu_req_valid and payload stay stable until cfu_req_ready; it clears on a CFU accept with no same-cycle issue accept.
REQ-019 issue_ready = (~cfu_req_valid | cfu_req_ready) & (outstanding < MAX_OUTSTANDING) & ~timeout_err; back-to-back issue at one per cycle while the CFU accepts every cycle.
REQ-020 outstanding increments on issue accept, decrements on wb accept, and stays unchanged when both occur in the same cycle; it never exceeds MAX_OUTSTANDING or wraps below 0.
REQ-021 Response buffer: 2-entry FIFO, in-order; cfu_resp_ready = FIFO not full; entry = {id, data, status} captured unmodified.
REQ-022 wb_valid = FIFO not empty; wb_id/data/status = head entry; head is stable while wb_valid & ~wb_ready.
REQ-023 A simultaneous push and pop on a full FIFO is not possible (ready is low); on a non-full, non-empty FIFO the occupancy is unchanged and ordering is preserved.
REQ-024 A response arriving into an empty FIFO appears on wb_valid the following cycle (1-cycle latency); the FIFO has no combinational path from cfu_resp to wb.
REQ-025 Tracker FSM states: IDLE (outstanding==0), BUSY (outstanding>0), ERROR.
REQ-026 IDLE->BUSY on issue accept; BUSY->IDLE when outstanding reaches 0; any->ERROR on timeout; ERROR exits only on reset.
REQ-027 Timeout counter: 8+ bits; cleared in IDLE and on every CFU response accept; otherwise increments in BUSY.
REQ-028 The FSM enters ERROR when the timeout counter equals TIMEOUT; timeout_err is 1 exactly while the FSM is in ERROR.
REQ-029 In ERROR:
- issue_ready = 0.
- The request register and the response path keep operating, so late responses still drain to writeback.
REQ-030 issue_id values are not checked for uniqueness; cfu_resp_id is not compared against issued IDs.

Reset
REQ-031 While rst_n=0 at a clock edge, all of the following hold at the next edge:
- cfu_req_valid=0, wb_valid=0, timeout_err=0, outstanding=0.
- FSM=IDLE, timeout counter=0, FIFO empty.
REQ-032 Reset mid-operation discards the pending request and buffered responses; payload outputs are don't-care while their valid is 0.
REQ-033 During reset, issue_ready=0 and cfu_resp_ready=0.

Verification
REQ-034 Single op: issue id=2, rs1=0x5, rs2=0x3; CFU responds with id=2, data=0xFFFFFFF9, status=0 two cycles later -> wb_valid=1 for one cycle with those values; outstanding 0->1->0.
REQ-035 Limit: issue 4 ops with no CFU responses and cfu_req_ready=1 -> issue_ready=0 after the 4th accept, outstanding=4; one wb accept -> issue_ready=1 the next cycle.
REQ-036 Backpressure: wb_ready=0, 3 responses offered -> 2 are buffered and cfu_resp_ready=0; release wb_ready -> ids are delivered in arrival order, with no loss or duplication.
REQ-037 Simultaneous: issue accept and wb accept in the same cycle with outstanding=2 -> outstanding stays 2.
REQ-038 Timeout: TIMEOUT=10, one op issued, no response -> timeout_err=1 at the 10th BUSY cycle and issue_ready=0; a late response still reaches wb; timeout_err clears only on rst_n=0.
REQ-039 Mid-op reset: rst_n=0 with wb_valid=1, FIFO holding 2 entries, and cfu_req_valid=1 -> all valids=0 and outstanding=0 the next cycle.
